// File: rtl/pulse_pkg.sv
// rtl/pulse_pkg.sv - shared state encoding and default timing constants for the pulse train checker
package pulse_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        TAIL  = 3'd4
    } ptc_state_t;

    localparam int DEF_N_PULSES = 5;
    localparam int DEF_HIGH_W   = 1;
    localparam int DEF_LOW_W    = 1;
    localparam int DEF_TIMEOUT  = 16;
    localparam int DEF_QUIET    = 2;

    // Largest of four widths; sizes the shared width counter.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - two-flop sample register with registered rise/fall decode
module edge_sync (
    input  logic CLK,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic q_prev;

    // Sample the line, then keep one cycle of history for edge detection.
    always_ff @(posedge CLK) begin
        if (reset) begin
            q      <= 1'b0;
            q_prev <= 1'b0;
        end else begin
            q      <= d;
            q_prev <= q;
        end
    end

    // Edges come only from registered bits, so nothing downstream sees d combinationally.
    assign rise = q & ~q_prev;
    assign fall = ~q & q_prev;

endmodule

// File: rtl/pulse_train_checker.sv
// rtl/pulse_train_checker.sv - checks a serial pulse train for pulse count, pulse width and gap width
module pulse_train_checker
    import pulse_pkg::*;
#(
    parameter int N_PULSES = DEF_N_PULSES,
    parameter int HIGH_W   = DEF_HIGH_W,
    parameter int LOW_W    = DEF_LOW_W,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int QUIET    = DEF_QUIET,
    parameter int CW       = $clog2(N_PULSES + 1)
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          arm,
    input  logic          serial_in,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [CW-1:0] pulse_count
);

    localparam int WMAX = max4(HIGH_W, LOW_W, QUIET, TIMEOUT);
    localparam int WW   = $clog2(WMAX + 1);

    // Limits carry one extra bit so wcnt+1 never wraps before it is compared.
    localparam logic [WW:0]   HIGH_LIM    = (WW+1)'(HIGH_W);
    localparam logic [WW:0]   LOW_LIM     = (WW+1)'(LOW_W);
    localparam logic [WW:0]   TIMEOUT_LIM = (WW+1)'(TIMEOUT);
    localparam logic [WW:0]   QUIET_LIM   = (WW+1)'(QUIET);
    localparam logic [CW-1:0] COUNT_MAX   = CW'(N_PULSES);

    ptc_state_t    state;
    logic [WW-1:0] wcnt;
    logic [WW:0]   wnext;
    logic          s_q;
    logic          rise;
    logic          fall;

    edge_sync u_edge_sync (
        .CLK   (CLK),
        .reset (reset),
        .d     (serial_in),
        .q     (s_q),
        .rise  (rise),
        .fall  (fall)
    );

    assign wnext = {1'b0, wcnt} + (WW+1)'(1);
    assign busy  = (state != IDLE);

    // Main checker FSM: arm restarts from any state, every failed check lands in IDLE with error set.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state       <= IDLE;
            done        <= 1'b0;
            error       <= 1'b0;
            pulse_count <= '0;
            wcnt        <= '0;
        end else if (arm) begin
            state       <= ARMED;
            done        <= 1'b0;
            error       <= 1'b0;
            pulse_count <= '0;
            wcnt        <= '0;
        end else begin
            case (state)
                ARMED: begin
                    if (rise) begin
                        state       <= HIGH;
                        pulse_count <= CW'(1);
                        wcnt        <= WW'(1);
                    end else if (wnext == TIMEOUT_LIM) begin
                        state <= IDLE;
                        error <= 1'b1;
                    end else begin
                        wcnt <= wnext[WW-1:0];
                    end
                end
                HIGH: begin
                    if (fall) begin
                        if ({1'b0, wcnt} != HIGH_LIM) begin
                            state <= IDLE;
                            error <= 1'b1;
                        end else if (pulse_count == COUNT_MAX) begin
                            state <= TAIL;
                            wcnt  <= WW'(1);
                        end else begin
                            state <= LOW;
                            wcnt  <= WW'(1);
                        end
                    end else if (wnext > HIGH_LIM) begin
                        state <= IDLE;
                        error <= 1'b1;
                    end else begin
                        wcnt <= wnext[WW-1:0];
                    end
                end
                LOW: begin
                    if (rise) begin
                        if ({1'b0, wcnt} != LOW_LIM) begin
                            state <= IDLE;
                            error <= 1'b1;
                        end else begin
                            state <= HIGH;
                            wcnt  <= WW'(1);
                            if (pulse_count != COUNT_MAX) begin
                                pulse_count <= pulse_count + CW'(1);
                            end
                        end
                    end else if (wnext > LOW_LIM) begin
                        state <= IDLE;
                        error <= 1'b1;
                    end else begin
                        wcnt <= wnext[WW-1:0];
                    end
                end
                TAIL: begin
                    if (s_q) begin
                        state <= IDLE;
                        error <= 1'b1;
                    end else if (wnext >= QUIET_LIM) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        wcnt <= wnext[WW-1:0];
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_train_checker.sv
// tb/tb_pulse_train_checker.sv - randomized and directed self-checking bench for pulse_train_checker
module tb_pulse_train_checker;
    import pulse_pkg::*;

    localparam int CW = $clog2(DEF_N_PULSES + 1);

    logic          CLK = 1'b0;
    logic          reset;
    logic          arm;
    logic          serial_in;
    logic          busy;
    logic          done;
    logic          error;
    logic [CW-1:0] pulse_count;

    int   vec_cnt = 0;
    int   mis_cnt = 0;
    logic stim[$];
    int   rises[$];
    int   m_end;
    bit   m_ok;

    pulse_train_checker dut (
        .CLK         (CLK),
        .reset       (reset),
        .arm         (arm),
        .serial_in   (serial_in),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .pulse_count (pulse_count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] obs_v();
        return 8'({busy, done, error, pulse_count});
    endfunction

    function automatic logic [7:0] expv(input bit b, input bit d, input bit e, input int c);
        return 8'({b, d, e, CW'(c)});
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        vec_cnt++;
        assert (obs === exp_v) else begin
            mis_cnt++;
            $error("FAIL %s: observed {busy,done,error,count}=%h expected %h", tag, obs, exp_v);
        end
    endtask

    // Length of the run of level lvl starting at index i; a low line past the stimulus end counts as endless.
    function automatic int runlen(input int i, input logic lvl);
        int r;
        r = 0;
        while (i + r < stim.size() && stim[i + r] == lvl) r++;
        if (i + r >= stim.size() && lvl == 1'b0) r = r + 100;
        return r;
    endfunction

    function automatic int count_at(input int c);
        int n;
        n = 0;
        foreach (rises[k]) if (rises[k] <= c) n++;
        return n;
    endfunction

    // Reference: stim[j] is the line during cycle j (arm in cycle 0); a decision on it lands on edge j+1.
    task automatic model();
        int  i;
        int  r;
        int  p;
        bit  fin;
        rises.delete();
        m_ok = 1'b0;
        i = 1;
        while (i < stim.size() && stim[i] == 1'b0) i++;
        fin = 1'b0;
        if (i >= DEF_TIMEOUT) begin
            m_end = DEF_TIMEOUT;
            fin   = 1'b1;
        end
        p = 0;
        while (!fin) begin
            p++;
            rises.push_back(i + 1);
            r = runlen(i, 1'b1);
            if (r != DEF_HIGH_W) begin
                m_end = i + ((r > DEF_HIGH_W) ? DEF_HIGH_W : r) + 1;
                fin   = 1'b1;
            end else begin
                i = i + r;
                r = runlen(i, 1'b0);
                if (p == DEF_N_PULSES) begin
                    fin = 1'b1;
                    if (r >= DEF_QUIET) begin
                        m_end = i + DEF_QUIET;
                        m_ok  = 1'b1;
                    end else begin
                        m_end = i + r + 1;
                    end
                end else if (r != DEF_LOW_W) begin
                    m_end = i + ((r > DEF_LOW_W) ? DEF_LOW_W : r) + 1;
                    fin   = 1'b1;
                end else begin
                    i = i + r;
                end
            end
        end
    endtask

    // Arm in cycle 0 and play stim; stop_at >= 0 cuts the run short before that cycle.
    task automatic run_trial(input string tag, input int stop_at);
        int last;
        model();
        last = (stop_at >= 0) ? stop_at - 1 : m_end + 2;
        for (int c = 0; c <= last; c++) begin
            arm       = (c == 0);
            serial_in = (c < stim.size()) ? stim[c] : 1'b0;
            @(posedge CLK);
            @(negedge CLK);
            if (c < m_end) check(tag, obs_v(), expv(1'b1, 1'b0, 1'b0, count_at(c)));
            else           check(tag, obs_v(), expv(1'b0, m_ok, !m_ok, rises.size()));
        end
        arm       = 1'b0;
        serial_in = 1'b0;
    endtask

    task automatic idle(input int n);
        arm       = 1'b0;
        serial_in = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    task automatic load(input logic [31:0] bits, input int len);
        stim.delete();
        stim.push_back(1'b0);
        stim.push_back(1'b0);
        for (int k = len - 1; k >= 0; k--) stim.push_back(bits[k]);
        for (int k = 0; k < 20; k++) stim.push_back(1'b0);
    endtask

    task automatic gen();
        int pre;
        int np;
        int bad;
        int w;
        stim.delete();
        stim.push_back(1'b0);
        pre = ($urandom_range(0, 7) == 0) ? DEF_TIMEOUT + int'($urandom_range(0, 2)) : int'($urandom_range(1, 8));
        for (int k = 1; k < pre; k++) stim.push_back(1'b0);
        np = DEF_N_PULSES;
        if ($urandom_range(0, 3) == 0) np = ($urandom_range(0, 1) == 1) ? DEF_N_PULSES + 1 : DEF_N_PULSES - 1;
        bad = ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(0, 2 * np - 2));
        for (int p = 0; p < np; p++) begin
            w = (bad == 2 * p) ? 2 : DEF_HIGH_W;
            for (int k = 0; k < w; k++) stim.push_back(1'b1);
            if (p < np - 1) begin
                w = (bad == 2 * p + 1) ? 2 : DEF_LOW_W;
                for (int k = 0; k < w; k++) stim.push_back(1'b0);
            end
        end
        for (int k = 0; k < 20; k++) stim.push_back(1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        arm       = 1'b0;
        serial_in = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("reset_state", obs_v(), expv(1'b0, 1'b0, 1'b0, 0));
        @(negedge CLK);
        reset = 1'b0;
        idle(2);
        check("idle_after_reset", obs_v(), expv(1'b0, 1'b0, 1'b0, 0));

        load(32'b0101010101, 10);
        run_trial("nominal", -1);
        idle(3);
        check("done_hold", obs_v(), expv(1'b0, 1'b1, 1'b0, DEF_N_PULSES));

        load(32'b01010101, 8);
        run_trial("short_train", -1);
        idle(2);
        load(32'b0110101010, 10);
        run_trial("wide_pulse", -1);
        idle(2);
        load(32'b010101010101, 12);
        run_trial("extra_pulse", -1);
        idle(2);
        load(32'b0, 0);
        run_trial("timeout", -1);
        idle(3);
        check("error_hold", obs_v(), expv(1'b0, 1'b0, 1'b1, 0));
        load(32'b1010101010, 23);
        run_trial("late_first_pulse", -1);
        idle(2);

        load(32'b0101010101, 10);
        run_trial("abort_pre", 10);
        load(32'b0101010101, 10);
        run_trial("abort_restart", -1);
        idle(2);

        load(32'b0101010101, 10);
        run_trial("reset_pre", 9);
        reset     = 1'b1;
        serial_in = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("reset_mid_train", obs_v(), expv(1'b0, 1'b0, 1'b0, 0));
        arm = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("reset_beats_arm", obs_v(), expv(1'b0, 1'b0, 1'b0, 0));
        reset = 1'b0;
        idle(2);

        for (int t = 0; t < 40; t++) begin
            gen();
            run_trial("random", -1);
            idle(2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule
